se_share_arbiter: RTL
=====================

Name: se_share_arbiter

Overview:
Two-requester arbiter and sequencer for a single shared immediate extender (18-bit to 32-bit) in the CPU datapath.
- Requester 0 is the ALU-immediate path; requester 1 is the branch/jump-offset path.
- Grants one request per cycle, round-robin.
- Extends the granted immediate by sign or zero extension.
- Presents the result in a one-entry registered output buffer with a valid/ready handshake, tagged with the requester ID.

Parameters:
IN_W, 18, immediate input width.
OUT_W, 32, extended output width; must be greater than IN_W.

Ports:
clk  input  1  single clock, rising edge.
reset  input  1  synchronous, active-high reset.
req0_valid  input  1  requester 0 has an immediate pending.
req0_imm  input  IN_W  requester 0 immediate.
req0_zext  input  1  1 = zero extend, 0 = sign extend.
req0_ready  output  1  requester 0 request accepted this cycle.
req1_valid  input  1  requester 1 has an immediate pending.
req1_imm  input  IN_W  requester 1 immediate.
req1_zext  input  1  1 = zero extend, 0 = sign extend.
req1_ready  output  1  requester 1 request accepted this cycle.
out_valid  output  1  out_data/out_id hold a valid result.
out_ready  input  1  consumer takes the result this cycle.
out_data  output  OUT_W  extended immediate.
out_id  output  1  ID of the requester that produced out_data.

Behaviour:
- Reset values:
  - out_valid=0, out_data=0, out_id=0.
  - req0_ready=0, req1_ready=0.
  - last_grant=1, so requester 0 wins the first contention.
  - FSM=EMPTY.
- FSM has two states:
  - EMPTY: buffer empty.
  - FULL: buffer holds a result.
- Accept condition (combinational): can_accept = (state==EMPTY) | (out_valid & out_ready).
- Arbitration, only when can_accept:
  - Exactly one valid requester: it is granted.
  - Both valid: the requester other than last_grant is granted.
  - Neither valid: no grant.
  - reqN_ready is high only for the granted requester; it is combinational and never high for both.
- On a grant at rising edge N:
  - out_data <= ext(imm), out_id <= granted ID, out_valid <= 1, last_grant <= granted ID.
  - The result is visible in cycle N+1 (latency 1).
- Extension rules:
  - zext=1: upper OUT_W-IN_W bits are 0.
  - zext=0: upper bits replicate imm[IN_W-1].
  - Low IN_W bits always equal imm.
- Transitions:
  - EMPTY -> FULL on grant.
  - FULL -> EMPTY on out_ready with no new grant.
  - FULL -> FULL on out_ready with a grant (back-to-back; one result per cycle sustained).
  - FULL -> FULL holding on !out_ready; out_data/out_id remain stable.
- Backpressure: while FULL & !out_ready, no requester is readied. Requesters must hold valid, imm and zext stable until they see ready.
- Fairness: with both requesters held valid continuously and out_ready=1, grants strictly alternate 0,1,0,1. Neither requester waits more than one grant.
- last_grant changes only on a grant, not on idle cycles.
- Reset mid-operation: the buffered result is discarded (out_valid=0 the next cycle) and last_grant returns to 1. No ready is asserted in the reset cycle.

Optional Feature:
SE_ARB_STATS_EN
- Defined:
  - Adds outputs grant_cnt0 and grant_cnt1 (16 bits each), each incremented on its requester's grant.
  - Counters saturate at 16'hFFFF and do not wrap.
  - Adds output stall_cnt (16 bits, saturating), incremented each cycle with state==FULL & !out_ready.
  - All three reset to 0.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package se_arb_pkg holds:
  - the state typedef (EMPTY, FULL);
  - ID constants REQ_ALU=0 and REQ_BR=1;
  - default width constants IN_W_DEF=18, OUT_W_DEF=32;
  - STAT_W=16.
- One natural sub-module: se_ext, a purely combinational extender (imm, zext -> ext), parameterized by IN_W/OUT_W and instantiated once on the granted path.

Test Plan:
- req0 imm=3782, zext=0, out_ready=1 -> req0_ready=1 in the same cycle; next cycle out_valid=1, out_data=32'h00000EC6, out_id=0.
- req1 imm=18'h3FFD5 (-43), zext=0 -> out_data=32'hFFFFFFD5 (signed -43), out_id=1. Same imm with zext=1 -> 32'h0003FFD5.
- Both valid from reset, out_ready=1, held for 6 cycles -> out_id sequence 0,1,0,1,0,1; never both readys high.
- Buffer FULL with out_ready=0 for 4 cycles while req0 is valid -> req0_ready=0 throughout and out_data stable. out_ready=1 -> drain and new grant in the same cycle, no bubble.
- reset asserted while FULL with req1 pending -> next cycle out_valid=0. After release with both valid -> requester 0 granted first.
- With SE_ARB_STATS_EN defined:
  - 3 grants to req0 and 2 to req1 -> grant_cnt0=3, grant_cnt1=2.
  - Forcing grant_cnt0 to 16'hFFFF then granting -> it stays at 16'hFFFF.

Source files
------------

// File: rtl/se_arb_pkg.sv
// se_arb_pkg: shared types and constants for the sign/zero-extend arbiter.
//   se_state_e : output-buffer FSM state (EMPTY, FULL)
//   REQ_ALU/REQ_BR : requester IDs carried on out_id
//   IN_W_DEF/OUT_W_DEF : default immediate / extended widths
//   STAT_W : width of the optional statistics counters
//   sat_inc : saturating increment for the statistics counters
package se_arb_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } se_state_e;

  localparam logic REQ_ALU   = 1'b0;
  localparam logic REQ_BR    = 1'b1;
  localparam int   IN_W_DEF  = 18;
  localparam int   OUT_W_DEF = 32;
  localparam int   STAT_W    = 16;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/se_share_arbiter_ext.sv
// se_ext: purely combinational immediate extender.
//   imm  : IN_W-bit immediate
//   zext : 1 = zero extend, 0 = sign extend from imm[IN_W-1]
//   ext  : OUT_W-bit result; low IN_W bits always equal imm
module se_ext #(
  parameter int IN_W  = 18,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]  imm,
  input  logic             zext,
  output logic [OUT_W-1:0] ext
);

  logic fill;

  assign fill = zext ? 1'b0 : imm[IN_W-1];
  assign ext  = {{(OUT_W-IN_W){fill}}, imm};

endmodule

// File: rtl/se_share_arbiter.sv
// se_share_arbiter: two-requester round-robin arbiter in front of one shared
// immediate extender, with a one-entry registered output buffer.
//   clk, reset            : rising-edge clock, synchronous active-high reset
//   req0_* / req1_*       : ALU-immediate / branch-offset requesters
//   reqN_ready            : combinational grant for requester N this cycle
//   out_valid/out_ready   : output handshake; out_data/out_id hold the result
//   fsm_state             : debug view of the buffer FSM
// Optional macro SE_ARB_STATS_EN adds grant_cnt0, grant_cnt1 and stall_cnt
// (saturating 16-bit counters).
//
// Handshake: a transfer happens in a cycle where valid and ready are both
// high at the rising edge. Requesters hold valid/imm/zext stable until they
// see ready; the consumer may leave out_valid pending as long as it likes,
// and out_data/out_id stay stable meanwhile.
module se_share_arbiter
  import se_arb_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [IN_W-1:0]  req0_imm,
  input  logic             req0_zext,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [IN_W-1:0]  req1_imm,
  input  logic             req1_zext,
  output logic             req1_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_id,
`ifdef SE_ARB_STATS_EN
  output logic [STAT_W-1:0] grant_cnt0,
  output logic [STAT_W-1:0] grant_cnt1,
  output logic [STAT_W-1:0] stall_cnt,
`endif
  output se_state_e        fsm_state
);

  se_state_e        state;
  logic             last_grant;
  logic             can_accept;
  logic             grant_valid;
  logic             grant_id;
  logic [IN_W-1:0]  imm_sel;
  logic             zext_sel;
  logic [OUT_W-1:0] ext_data;

  // The buffer can take a new result when empty or when it drains this cycle.
  assign can_accept  = (state == EMPTY) | (out_valid & out_ready);
  // Readies are suppressed in the reset cycle so nothing is lost.
  assign grant_valid = can_accept & (req0_valid | req1_valid) & ~reset;
  // Under contention the requester that did not win last time goes next.
  assign grant_id    = (req0_valid & req1_valid) ? ~last_grant : req1_valid;

  assign req0_ready  = grant_valid & (grant_id == REQ_ALU);
  assign req1_ready  = grant_valid & (grant_id == REQ_BR);

  assign imm_sel     = grant_id ? req1_imm  : req0_imm;
  assign zext_sel    = grant_id ? req1_zext : req0_zext;
  assign fsm_state   = state;

  se_ext #(
    .IN_W (IN_W),
    .OUT_W(OUT_W)
  ) u_ext (
    .imm (imm_sel),
    .zext(zext_sel),
    .ext (ext_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= EMPTY;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_id     <= REQ_ALU;
      last_grant <= REQ_BR;
    end else begin
      case (state)
        EMPTY: begin
          if (grant_valid) begin
            state      <= FULL;
            out_valid  <= 1'b1;
            out_data   <= ext_data;
            out_id     <= grant_id;
            last_grant <= grant_id;
          end
        end
        FULL: begin
          if (grant_valid) begin
            // Drain and refill in the same cycle: no bubble.
            out_valid  <= 1'b1;
            out_data   <= ext_data;
            out_id     <= grant_id;
            last_grant <= grant_id;
          end else if (out_ready) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef SE_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
      stall_cnt  <= '0;
    end else begin
      if (req0_ready) grant_cnt0 <= sat_inc(grant_cnt0);
      if (req1_ready) grant_cnt1 <= sat_inc(grant_cnt1);
      if ((state == FULL) && !out_ready) stall_cnt <= sat_inc(stall_cnt);
    end
  end
`endif

endmodule
